sq_eg: RTL and testbench
========================

// Module: sq_eg
// PURPOSE
//  ADSR envelope generator for one sq_slot operator. Sits between sq_sin and sq_pow.
//  Adds a time-varying attenuation to the log-domain sine sample sq_sin produces, in the
//  same 13-bit log format (exp/mantissa/sign), so sq_pow's antilog yields the enveloped
//  linear output. Attenuation 0 = full level; 0xFFF = silent.
// PARAMETERS
//  AW       12   attenuation / log-magnitude width (bits [12:1] of the log word)
//  PRESC_W  15   free-running rate prescaler width
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous, active-high reset
//  keyon     in   1   level; rising edge starts attack, falling edge starts release
//  ar        in   4   attack rate, 0 = frozen, 15 = fastest
//  dr        in   4   decay rate, same encoding
//  sl        in   4   sustain level; level = {sl,8'h00}, sl=15 -> 0xFFF
//  rr        in   4   release rate, same encoding
//  sin_log   in   13  log sample from sq_sin: [12:9] exp, [8:1] mantissa, [0] sign (1 = neg)
//  eg_log    out  13  sin_log with attenuation applied; feeds sq_pow x
//  eg_state  out  3   0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//  atten     out  12  current attenuation register
// BEHAVIOUR
//  - Reset (sync, every register): atten=0xFFF, eg_state=IDLE, eg_log=13'h1FFE,
//    presc=0, keyon_d=0. Reset mid-operation aborts any state on the next edge.
//  - presc: PRESC_W-bit counter, +1 every cycle, wraps. For active rate R:
//    mask = 15'h7FFF >> R; step = (R!=0) && ((presc & mask)==0). R=15 steps every cycle;
//    R=1 every 16384 cycles. R=0 never steps; atten holds.
//  - Edge detect: rise = keyon & ~keyon_d; fall = ~keyon & keyon_d (mutually exclusive).
//  - rise (any state): ->ATTACK, atten unchanged; if ar==15 then atten<=0, ->DECAY
//    in the same edge.
//  - fall (any state other than IDLE): ->RELEASE, atten unchanged. Edges take priority
//    over a step in the same cycle.
//  - ATTACK, on step(ar): atten <= atten - ((atten>>4)+1), floor 0; when result==0 ->DECAY.
//  - DECAY, on step(dr): if atten+1 >= sl_level then atten<=sl_level, ->SUSTAIN; else
//    atten+1. If entering DECAY with atten>=sl_level (e.g. sl=0), the next step clamps
//    to sl_level and goes to SUSTAIN.
//  - SUSTAIN: atten holds while keyon is high.
//  - RELEASE, on step(rr): atten <= min(atten+1, 0xFFF); on reaching 0xFFF ->IDLE.
//  - IDLE: atten holds at 0xFFF.
//  - Output (registered, 1-cycle latency from sin_log):
//    sum = sin_log[12:1] + atten (13-bit);
//    eg_log <= {sum>0xFFF ? 12'hFFF : sum[11:0], sin_log[0]}.
//    The atten used is the register value before the same edge updates it.
//  - Sign bit passes through unmodified; no combinational path from inputs to outputs.
// TESTING
//  1 reset held 2 cycles mid-ATTACK -> eg_state=0, atten=0xFFF, eg_log=0x1FFE next cycle.
//  2 ar=15, dr=15, sl=2, keyon 0->1 -> atten=0 and DECAY after 1 edge;
//    512 cycles later atten=0x200, SUSTAIN.
//  3 ar=14 from IDLE, keyon rise -> first step within 2 cycles gives atten=0xEFF;
//    monotonically decreasing to 0, then DECAY.
//  4 atten=0x200 held: sin_log=0x0201 -> eg_log=0x0601;
//    sin_log=0x1E01 -> eg_log=0x1FFF (saturated, sign kept).
//  5 SUSTAIN at 0x200, rr=15, keyon fall -> RELEASE; atten reaches 0xFFF after 0xDFF
//    cycles, then IDLE.
//  6 DECAY with dr=0 -> atten frozen for 20000 cycles; keyon rise during RELEASE
//    -> ATTACK from the current atten.

Source files
------------

// File: rtl/sq_eg.sv
// ADSR envelope generator: adds a time-varying attenuation to the log-domain sine
// sample from sq_sin. Attenuation 0 is full level, all-ones is silent.
module sq_eg #(
  parameter int unsigned AW      = 12,
  parameter int unsigned PRESC_W = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          keyon,
  input  logic [3:0]    ar,
  input  logic [3:0]    dr,
  input  logic [3:0]    sl,
  input  logic [3:0]    rr,
  input  logic [AW:0]   sin_log,
  output logic [AW:0]   eg_log,
  output logic [2:0]    eg_state,
  output logic [AW-1:0] atten
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [AW-1:0]        r_atten;
  logic [AW-1:0]        w_atten_nxt;
  logic [AW:0]          r_eg_log;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_keyon_d;

  logic                 w_rise;
  logic                 w_fall;
  logic [AW-1:0]        w_sl_level;
  logic [AW-1:0]        w_dec;
  logic [AW:0]          w_inc;
  logic [AW:0]          w_sum;
  logic [AW-1:0]        w_sat;

  // A rate R steps once every 2^(PRESC_W-R) cycles; R=0 never steps.
  function automatic logic rate_step(input logic [3:0] r, input logic [PRESC_W-1:0] p);
    logic [PRESC_W-1:0] mask;
    mask = {PRESC_W{1'b1}} >> r;
    return (r != 4'd0) && ((p & mask) == '0);
  endfunction

  assign w_rise     = keyon & ~r_keyon_d;
  assign w_fall     = ~keyon & r_keyon_d;
  // sl=15 maps to fully silent rather than 0xF00.
  assign w_sl_level = (sl == 4'hF) ? {AW{1'b1}} : {sl, {(AW-4){1'b0}}};
  assign w_dec      = (r_atten >> 4) + 1'b1;
  assign w_inc      = {1'b0, r_atten} + 1'b1;
  assign w_sum      = {1'b0, sin_log[AW:1]} + {1'b0, r_atten};
  assign w_sat      = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];

  // State, attenuation, prescaler, edge detector and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_atten   <= {AW{1'b1}};
      r_eg_log  <= {{AW{1'b1}}, 1'b0};
      r_presc   <= '0;
      r_keyon_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_atten   <= w_atten_nxt;
      r_eg_log  <= {w_sat, sin_log[0]};
      r_presc   <= r_presc + 1'b1;
      r_keyon_d <= keyon;
    end
  end

  // Next state and attenuation; key edges win over a rate step in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_atten_nxt = r_atten;
    if (w_rise) begin
      if (ar == 4'hF) begin
        w_atten_nxt = '0;
        w_state_nxt = StDecay;
      end else begin
        w_state_nxt = StAttack;
      end
    end else if (w_fall && (r_state != StIdle)) begin
      w_state_nxt = StRelease;
    end else begin
      unique case (r_state)
        StAttack: begin
          if (rate_step(ar, r_presc)) begin
            if (w_dec >= r_atten) begin
              w_atten_nxt = '0;
              w_state_nxt = StDecay;
            end else begin
              w_atten_nxt = r_atten - w_dec;
            end
          end
        end
        StDecay: begin
          if (rate_step(dr, r_presc)) begin
            if (w_inc >= {1'b0, w_sl_level}) begin
              w_atten_nxt = w_sl_level;
              w_state_nxt = StSustain;
            end else begin
              w_atten_nxt = w_inc[AW-1:0];
            end
          end
        end
        StRelease: begin
          if (rate_step(rr, r_presc)) begin
            if (w_inc >= {1'b0, {AW{1'b1}}}) begin
              w_atten_nxt = {AW{1'b1}};
              w_state_nxt = StIdle;
            end else begin
              w_atten_nxt = w_inc[AW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are straight from registers.
  always_comb begin
    eg_state = r_state;
    atten    = r_atten;
    eg_log   = r_eg_log;
  end

endmodule

// File: tb/tb_sq_eg.sv
// Self-checking bench for sq_eg against an arithmetic envelope model.
module tb_sq_eg;

  logic        clk = 1'b0;
  logic        reset;
  logic        keyon;
  logic [3:0]  ar, dr, sl, rr;
  logic [12:0] sin_log;
  logic [12:0] eg_log;
  logic [2:0]  eg_state;
  logic [11:0] atten;

  int checks = 0;
  int errors = 0;

  // Model: state numbers 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_state, m_atten, m_eg, m_presc, m_kd;

  sq_eg #(.AW(12), .PRESC_W(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .keyon    (keyon),
    .ar       (ar),
    .dr       (dr),
    .sl       (sl),
    .rr       (rr),
    .sin_log  (sin_log),
    .eg_log   (eg_log),
    .eg_state (eg_state),
    .atten    (atten)
  );

  always #5 clk = ~clk;

  function automatic bit stp(int r, int p);
    return (r != 0) && ((p % (1 << (15 - r))) == 0);
  endfunction

  // Advance the model by one edge using the current inputs, then cross the edge.
  task automatic tick();
    int sum, lvl, eg_n;
    bit rise, fall;
    if (reset) begin
      m_state = 0; m_atten = 4095; m_eg = 13'h1FFE; m_presc = 0; m_kd = 0;
    end else begin
      sum  = int'(sin_log[12:1]) + m_atten;
      eg_n = ((sum > 4095) ? 4095 : sum) * 2 + int'(sin_log[0]);
      rise = keyon && (m_kd == 0);
      fall = !keyon && (m_kd == 1);
      lvl  = (sl == 15) ? 4095 : int'(sl) * 256;
      if (rise) begin
        if (ar == 15) begin m_atten = 0; m_state = 2; end
        else m_state = 1;
      end else if (fall && m_state != 0) begin
        m_state = 4;
      end else begin
        case (m_state)
          1: if (stp(ar, m_presc)) begin
               m_atten = m_atten - (m_atten / 16 + 1);
               if (m_atten <= 0) begin m_atten = 0; m_state = 2; end
             end
          2: if (stp(dr, m_presc)) begin
               if (m_atten + 1 >= lvl) begin m_atten = lvl; m_state = 3; end
               else m_atten = m_atten + 1;
             end
          4: if (stp(rr, m_presc)) begin
               m_atten = (m_atten + 1 > 4095) ? 4095 : m_atten + 1;
               if (m_atten == 4095) m_state = 0;
             end
          default: ;
        endcase
      end
      m_eg    = eg_n;
      m_kd    = keyon ? 1 : 0;
      m_presc = (m_presc + 1) % 32768;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; keyon = 1'b0; ar = 4'd0; dr = 4'd0; sl = 4'd0; rr = 4'd0; sin_log = '0;
    tick(); tick();
    reset = 1'b0;
    ar = 4'd3; keyon = 1'b1;
    repeat (50) tick();
    checks++;
    if (eg_state !== 3'(m_state)) begin
      errors++; $display("FAIL pre_reset_state got %0d want %0d", eg_state, m_state);
    end
    reset = 1'b1; keyon = 1'b0;
    tick(); tick();
    checks++;
    if (eg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", eg_state);
    end
    checks++;
    if (atten !== 12'hFFF) begin
      errors++; $display("FAIL reset_atten got %h want fff", atten);
    end
    checks++;
    if (eg_log !== 13'h1FFE) begin
      errors++; $display("FAIL reset_eg_log got %h want 1ffe", eg_log);
    end
    reset = 1'b0;
  endtask

  task automatic test_fast_attack_decay();
    ar = 4'd15; dr = 4'd15; sl = 4'd2; keyon = 1'b1;
    tick();
    checks++;
    if (atten !== 12'h000 || eg_state !== 3'd2) begin
      errors++; $display("FAIL fast_attack got atten %h state %0d want 000 state 2", atten, eg_state);
    end
    repeat (511) tick();
    checks++;
    if (atten !== 12'h1FF || eg_state !== 3'd2) begin
      errors++; $display("FAIL decay_edge got atten %h state %0d want 1ff state 2", atten, eg_state);
    end
    tick();
    checks++;
    if (atten !== 12'h200 || eg_state !== 3'd3) begin
      errors++; $display("FAIL sustain got atten %h state %0d want 200 state 3", atten, eg_state);
    end
  endtask

  task automatic test_output();
    sin_log = 13'h0201;
    tick();
    checks++;
    if (eg_log !== 13'h0601) begin
      errors++; $display("FAIL out_add got %h want 0601", eg_log);
    end
    sin_log = 13'h1E01;
    tick();
    checks++;
    if (eg_log !== 13'h1FFF) begin
      errors++; $display("FAIL out_sat got %h want 1fff", eg_log);
    end
    for (int i = 0; i < 8; i++) begin
      sin_log = 13'($urandom);
      tick();
      checks++;
      if (eg_log !== 13'(m_eg)) begin
        errors++; $display("FAIL out_rand got %h want %h", eg_log, 13'(m_eg));
      end
    end
  endtask

  task automatic test_release();
    rr = 4'd15; keyon = 1'b0;
    tick();
    checks++;
    if (atten !== 12'h200 || eg_state !== 3'd4) begin
      errors++; $display("FAIL release_entry got atten %h state %0d want 200 state 4", atten, eg_state);
    end
    repeat (12'hDFE) tick();
    checks++;
    if (atten !== 12'hFFE || eg_state !== 3'd4) begin
      errors++; $display("FAIL release_edge got atten %h state %0d want ffe state 4", atten, eg_state);
    end
    tick();
    checks++;
    if (atten !== 12'hFFF || eg_state !== 3'd0) begin
      errors++; $display("FAIL release_done got atten %h state %0d want fff state 0", atten, eg_state);
    end
  endtask

  task automatic test_attack();
    int prev, first_cyc, first_val, cyc;
    bit done;
    ar = 4'd14; dr = 4'd0; sl = 4'd8; keyon = 1'b1;
    tick();
    checks++;
    if (eg_state !== 3'd1 || atten !== 12'hFFF) begin
      errors++; $display("FAIL attack_entry got atten %h state %0d want fff state 1", atten, eg_state);
    end
    first_cyc = -1; first_val = -1; done = 0; cyc = 0;
    while (!done && cyc < 5000) begin
      prev = atten;
      tick();
      cyc++;
      if (first_cyc < 0 && atten != 12'hFFF) begin first_cyc = cyc; first_val = atten; end
      checks++;
      if (int'(atten) > prev || atten !== 12'(m_atten) || eg_state !== 3'(m_state)) begin
        errors++;
        $display("FAIL attack_track got atten %h state %0d want %h state %0d (prev %h)",
                 atten, eg_state, 12'(m_atten), m_state, prev);
      end
      if (eg_state == 3'd2) done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL attack_timeout got state %0d want 2", eg_state);
    end
    checks++;
    if (first_cyc < 1 || first_cyc > 2 || first_val != 12'hEFF) begin
      errors++; $display("FAIL attack_first got %h at cycle %0d want eff within 2", first_val, first_cyc);
    end
    checks++;
    if (atten !== 12'h000) begin
      errors++; $display("FAIL attack_floor got %h want 000", atten);
    end
  endtask

  task automatic test_freeze();
    int held;
    held = m_atten;
    repeat (20000) tick();
    checks++;
    if (atten !== 12'(held) || eg_state !== 3'd2) begin
      errors++; $display("FAIL decay_frozen got atten %h state %0d want %h state 2", atten, eg_state, 12'(held));
    end
    rr = 4'd15; keyon = 1'b0;
    tick();
    repeat (100) tick();
    checks++;
    if (atten !== 12'(held + 100) || eg_state !== 3'd4) begin
      errors++; $display("FAIL release_run got atten %h state %0d want %h state 4", atten, eg_state, 12'(held + 100));
    end
    held = m_atten;
    ar = 4'd0; keyon = 1'b1;
    tick();
    checks++;
    if (atten !== 12'(held) || eg_state !== 3'd1) begin
      errors++; $display("FAIL reattack got atten %h state %0d want %h state 1", atten, eg_state, 12'(held));
    end
    repeat (50) tick();
    checks++;
    if (atten !== 12'(held) || eg_state !== 3'd1) begin
      errors++; $display("FAIL attack_frozen got atten %h state %0d want %h state 1", atten, eg_state, 12'(held));
    end
  endtask

  task automatic test_random();
    int local_err;
    local_err = 0;
    for (int i = 0; i < 6000 && local_err < 20; i++) begin
      sin_log = 13'($urandom);
      if ($urandom_range(0, 149) == 0) keyon = ~keyon;
      if ($urandom_range(0, 399) == 0) begin
        ar = 4'($urandom_range(8, 15)); dr = 4'($urandom_range(8, 15));
        rr = 4'($urandom_range(8, 15)); sl = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 1999) == 0);
      tick();
      checks++;
      if (eg_state !== 3'(m_state) || atten !== 12'(m_atten) || eg_log !== 13'(m_eg)) begin
        errors++; local_err++;
        $display("FAIL random got state %0d atten %h eg %h want state %0d atten %h eg %h",
                 eg_state, atten, eg_log, m_state, 12'(m_atten), 13'(m_eg));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fast_attack_decay();
    test_output();
    test_release();
    test_attack();
    test_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
